// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues one memory read at a time and hands the
// fetched word to the branch/execute stage through a valid/accept handshake.
module instruction_fetch #(
    parameter int unsigned     XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR    = 32'h00000000,
    parameter logic [XLEN-1:0] NOP_INSTRUCTION = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable_n,
    input  logic            load_new_program_counter,
    input  logic [XLEN-1:0] new_program_counter,
    output logic            mem_read_request,
    output logic [XLEN-1:0] mem_address,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_data,
    output logic            instruction_valid,
    input  logic            instruction_accept,
    output wire  [XLEN-1:0] instruction,
    output wire  [XLEN-1:0] program_counter
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_VALID,
        S_FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            valid_q, valid_d;

    logic            redirect;
    logic            accept;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_next;

    // A disabled stage must not react to the branch stage at all.
    assign redirect = load_new_program_counter && !enable_n;
    assign accept   = instruction_accept && !enable_n;
    assign target   = {new_program_counter[XLEN-1:2], 2'b00};
    assign pc_next  = pc_q + XLEN'(4);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        req_d      = req_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;

        unique case (state_q)
            S_FETCH: begin
                if (!req_q) begin
                    // Idle FETCH cycle: latch the address for the request that starts now.
                    if (redirect) begin
                        pc_d = target;
                    end else begin
                        req_d      = 1'b1;
                        req_addr_d = pc_q;
                    end
                end else if (redirect) begin
                    pc_d = target;
                    if (mem_ready) begin
                        req_d = 1'b0;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end else if (mem_ready) begin
                    instr_d    = mem_data;
                    instr_pc_d = req_addr_q;
                    valid_d    = 1'b1;
                    req_d      = 1'b0;
                    state_d    = S_VALID;
                end
            end
            S_VALID: begin
                if (redirect) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTRUCTION;
                    state_d = S_FETCH;
                end else if (accept) begin
                    pc_d       = pc_next;
                    valid_d    = 1'b0;
                    req_d      = 1'b1;
                    req_addr_d = pc_next;
                    state_d    = S_FETCH;
                end
            end
            S_FLUSH: begin
                // The stale read must finish before the redirected fetch can start.
                if (redirect) begin
                    pc_d = target;
                end
                if (mem_ready) begin
                    req_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_VECTOR;
            req_addr_q <= RESET_VECTOR;
            req_q      <= 1'b0;
            instr_q    <= NOP_INSTRUCTION;
            instr_pc_q <= RESET_VECTOR;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            req_q      <= req_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

    assign mem_read_request  = req_q;
    assign mem_address       = req_addr_q;
    assign instruction_valid = valid_q;
    assign instruction       = enable_n ? {XLEN{1'bz}} : instr_q;
    assign program_counter   = enable_n ? {XLEN{1'bz}} : instr_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a bench-side memory with programmable latency,
// expected {address, word} pairs queued as fetches are provoked and popped on each valid.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_n;
    logic        load_new_program_counter;
    logic [31:0] new_program_counter;
    logic        mem_read_request;
    logic [31:0] mem_address;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic        instruction_valid;
    logic        instruction_accept;
    wire  [31:0] instruction;
    wire  [31:0] program_counter;

    int          checks = 0;
    int          errors = 0;
    int          ready_delay = 0;
    int          wait_cnt = 0;
    logic [63:0] exp_q[$];

    instruction_fetch #(
        .XLEN           (32),
        .RESET_VECTOR   (32'h00000000),
        .NOP_INSTRUCTION(NOP)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .enable_n                (enable_n),
        .load_new_program_counter(load_new_program_counter),
        .new_program_counter     (new_program_counter),
        .mem_read_request        (mem_read_request),
        .mem_address             (mem_address),
        .mem_ready               (mem_ready),
        .mem_data                (mem_data),
        .instruction_valid       (instruction_valid),
        .instruction_accept      (instruction_accept),
        .instruction             (instruction),
        .program_counter         (program_counter)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h00000010) return 32'h00500093;
        return (a ^ 32'hC0DE0000) + 32'h00000003;
    endfunction

    // Memory answers after ready_delay cycles of a held request.
    always @(posedge clk) begin
        if (mem_read_request && !mem_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end
    assign mem_ready = mem_read_request && (wait_cnt >= ready_delay);
    assign mem_data  = mem_word(mem_address);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_fetch(input logic [31:0] a);
        exp_q.push_back({a, mem_word(a)});
    endtask

    task automatic wait_valid(input string name, output int n);
        logic [63:0] e;
        n = 1;
        tick();
        while (!instruction_valid && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (!instruction_valid) begin
            errors++;
            $display("FAIL %s_timeout: got valid=0 after %0d cycles, required valid=1", name, n);
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected: got pc=%h instr=%h, required no instruction", name,
                     program_counter, instruction);
        end else begin
            e = exp_q.pop_front();
            if (program_counter !== e[63:32] || instruction !== e[31:0]) begin
                errors++;
                $display("FAIL %s: got pc=%h instr=%h, required pc=%h instr=%h", name,
                         program_counter, instruction, e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic redirect_to(input logic [31:0] t);
        load_new_program_counter = 1'b1;
        new_program_counter      = t;
        tick();
        load_new_program_counter = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable_n = 1'b0; instruction_accept = 1'b0;
        load_new_program_counter = 1'b0; new_program_counter = '0;
        tick();
        tick();
        checks++;
        if (instruction_valid !== 1'b0 || mem_read_request !== 1'b0 ||
            instruction !== NOP || program_counter !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got v=%b req=%b instr=%h pc=%h, required v=0 req=0 instr=%h pc=0",
                     instruction_valid, mem_read_request, instruction, program_counter, NOP);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (mem_read_request !== 1'b1 || mem_address !== 32'h0) begin
            errors++;
            $display("FAIL first_request: got req=%b addr=%h, required req=1 addr=0",
                     mem_read_request, mem_address);
        end
    endtask

    task automatic test_sequential();
        int n;
        instruction_accept = 1'b1;
        for (int i = 0; i < 3; i++) expect_fetch(32'(i * 4));
        wait_valid("seq0", n);
        for (int i = 1; i < 3; i++) begin
            wait_valid("seq", n);
            checks++;
            if (n != 2) begin
                errors++;
                $display("FAIL seq_throughput: got %0d cycles between valids, required 2", n);
            end
        end
        instruction_accept = 1'b0;
    endtask

    task automatic test_stall();
        int n;
        redirect_to(32'h10);
        expect_fetch(32'h10);
        wait_valid("stall_fetch", n);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (instruction_valid !== 1'b1 || mem_read_request !== 1'b0 ||
                instruction !== 32'h00500093 || program_counter !== 32'h10) begin
                errors++;
                $display("FAIL stall_hold: got v=%b req=%b instr=%h pc=%h, required v=1 req=0 instr=00500093 pc=10",
                         instruction_valid, mem_read_request, instruction, program_counter);
            end
        end
        instruction_accept = 1'b1;
        tick();
        instruction_accept = 1'b0;
        checks++;
        if (mem_read_request !== 1'b1 || mem_address !== 32'h14) begin
            errors++;
            $display("FAIL stall_next_addr: got req=%b addr=%h, required req=1 addr=14",
                     mem_read_request, mem_address);
        end
        expect_fetch(32'h14);
        wait_valid("stall_next", n);
    endtask

    task automatic test_redirect_valid();
        int n;
        redirect_to(32'h20);
        expect_fetch(32'h20);
        wait_valid("redir_setup", n);
        instruction_accept = 1'b1;
        redirect_to(32'h103);
        instruction_accept = 1'b0;
        checks++;
        if (instruction_valid !== 1'b0 || instruction !== NOP) begin
            errors++;
            $display("FAIL redir_valid_flush: got v=%b instr=%h, required v=0 instr=%h",
                     instruction_valid, instruction, NOP);
        end
        tick();
        checks++;
        if (mem_read_request !== 1'b1 || mem_address !== 32'h100) begin
            errors++;
            $display("FAIL redir_valid_addr: got req=%b addr=%h, required req=1 addr=100",
                     mem_read_request, mem_address);
        end
        expect_fetch(32'h100);
        wait_valid("redir_valid_fetch", n);
    endtask

    task automatic test_redirect_inflight();
        int n;
        ready_delay = 3;
        redirect_to(32'h40);
        tick();
        tick();
        redirect_to(32'h200);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (mem_read_request !== 1'b1 || mem_address !== 32'h40 || instruction_valid !== 1'b0) begin
                errors++;
                $display("FAIL inflight_hold: got req=%b addr=%h v=%b, required req=1 addr=40 v=0",
                         mem_read_request, mem_address, instruction_valid);
            end
            tick();
        end
        ready_delay = 0;
        checks++;
        if (instruction_valid !== 1'b0 || mem_read_request !== 1'b0) begin
            errors++;
            $display("FAIL inflight_discard: got v=%b req=%b, required v=0 req=0",
                     instruction_valid, mem_read_request);
        end
        tick();
        checks++;
        if (mem_read_request !== 1'b1 || mem_address !== 32'h200) begin
            errors++;
            $display("FAIL inflight_new_addr: got req=%b addr=%h, required req=1 addr=200",
                     mem_read_request, mem_address);
        end
        expect_fetch(32'h200);
        wait_valid("inflight_fetch", n);
    endtask

    task automatic test_enable();
        enable_n = 1'b1;
        load_new_program_counter = 1'b1;
        new_program_counter = 32'h300;
        instruction_accept = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (instruction_valid !== 1'b1 || mem_read_request !== 1'b0) begin
                errors++;
                $display("FAIL disabled_hold: got v=%b req=%b, required v=1 req=0",
                         instruction_valid, mem_read_request);
            end
        end
        enable_n = 1'b0;
        load_new_program_counter = 1'b0;
        instruction_accept = 1'b0;
        #1;
        checks++;
        if (instruction !== mem_word(32'h200) || program_counter !== 32'h200) begin
            errors++;
            $display("FAIL enable_restore: got instr=%h pc=%h, required instr=%h pc=200",
                     instruction, program_counter, mem_word(32'h200));
        end
    endtask

    task automatic test_wrap_and_reset();
        int n;
        tick();
        redirect_to(32'hFFFFFFFC);
        expect_fetch(32'hFFFFFFFC);
        wait_valid("wrap_top", n);
        instruction_accept = 1'b1;
        tick();
        instruction_accept = 1'b0;
        checks++;
        if (mem_read_request !== 1'b1 || mem_address !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr: got req=%b addr=%h, required req=1 addr=0",
                     mem_read_request, mem_address);
        end
        expect_fetch(32'h0);
        wait_valid("wrap_fetch", n);
        ready_delay = 5;
        redirect_to(32'h80);
        tick();
        redirect_to(32'h400);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ready_delay = 0;
        checks++;
        if (instruction_valid !== 1'b0 || mem_read_request !== 1'b0 ||
            program_counter !== 32'h0 || instruction !== NOP) begin
            errors++;
            $display("FAIL flush_reset: got v=%b req=%b pc=%h instr=%h, required v=0 req=0 pc=0 instr=%h",
                     instruction_valid, mem_read_request, program_counter, instruction, NOP);
        end
        tick();
        checks++;
        if (mem_read_request !== 1'b1 || mem_address !== 32'h0) begin
            errors++;
            $display("FAIL flush_reset_addr: got req=%b addr=%h, required req=1 addr=0",
                     mem_read_request, mem_address);
        end
        expect_fetch(32'h0);
        wait_valid("post_reset_fetch", n);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_valid();
        test_redirect_inflight();
        test_enable();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
